// File: rtl/fdivider_prog.sv
// fdivider_prog: runtime-programmable integer divider producing a tick and square wave at f_clk/D.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en_i                count enable
//   phase_clr_i         restart the current period (wins over en_i)
//   ld_i, div_i         load strobe and new divisor (staged until a period boundary)
//   ld_ack_o            one-cycle pulse when a staged divisor becomes active
//   div_o, cnt_o        active divisor and phase counter
//   tick_o, sq_o        one-cycle tick at cnt==D-1, square wave (low ceil(D/2), high floor(D/2))
// Optional: define FDIVIDER_PROG_ODD50_EN to stretch the high phase of odd divisors by half a cycle
// (50% duty) using a falling-edge flop.
module fdivider_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             phase_clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             ld_ack_o,
  output logic [WIDTH-1:0] div_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tick_o,
  output logic             sq_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d, src;
  logic pend_v_q, pend_v_d, tick_q, tick_d, sq_q, sq_d, ack_q, ack_d;
  logic halted, wrap, apply;
  always_comb begin
    halted   = div_q == '0;
    wrap     = en_i && !halted && cnt_q == div_q - WIDTH'(1);
    // an incoming load bypasses the slot so a load on the boundary cycle is not lost
    src      = ld_i ? div_i : pend_q;
    // a halted divider (D=0) takes a new divisor on the next edge regardless of en_i
    apply    = (ld_i || pend_v_q) && (phase_clr_i || wrap || halted);
    div_d    = apply ? src : div_q;
    pend_v_d = !apply && (ld_i || pend_v_q);
    pend_d   = ld_i ? div_i : pend_q;
    cnt_d    = (phase_clr_i || halted || wrap) ? '0 : en_i ? cnt_q + WIDTH'(1) : cnt_q;
    // outputs are decoded from the next count and next divisor so they line up with cnt_o
    tick_d   = !phase_clr_i && en_i && div_d != '0 && cnt_d == div_d - WIDTH'(1);
    sq_d     = phase_clr_i ? 1'b0 :
               en_i ? (div_d >= WIDTH'(2) && cnt_d >= div_d - (div_d >> 1)) : sq_q;
    ack_d    = apply;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= WIDTH'(RESET_DIV);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
      ack_q    <= ack_d;
    end
  end
`ifdef FDIVIDER_PROG_ODD50_EN
  logic sq_n_q;
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) sq_n_q <= 1'b0;
    else        sq_n_q <= sq_q;
  end
  // the half-cycle delayed copy only extends the high phase for odd D>=3
  assign sq_o = sq_q | (sq_n_q & div_q[0] & (div_q >= WIDTH'(3)));
`else
  assign sq_o = sq_q;
`endif
  assign cnt_o    = cnt_q;
  assign div_o    = div_q;
  assign tick_o   = tick_q;
  assign ld_ack_o = ack_q;
endmodule

// File: tb/tb_fdivider_prog.sv
// tb_fdivider_prog: directed self-checking bench for fdivider_prog (WIDTH=8, RESET_DIV=2).
module tb_fdivider_prog;
  logic clk = 1'b0, rst_n = 1'b0, en_i = 1'b0, phase_clr_i = 1'b0, ld_i = 1'b0;
  logic [7:0] div_i = '0;
  logic ld_ack_o, tick_o, sq_o;
  logic [7:0] div_o, cnt_o;
  int checks = 0, failures = 0;

  fdivider_prog #(.WIDTH(8), .RESET_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .phase_clr_i(phase_clr_i), .ld_i(ld_i),
    .div_i(div_i), .ld_ack_o(ld_ack_o), .div_o(div_o), .cnt_o(cnt_o), .tick_o(tick_o), .sq_o(sq_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_i = 1'b1;
    repeat (3) step();
    checks++;
    if ({cnt_o, div_o, tick_o, sq_o, ld_ack_o} !== {8'd0, 8'd2, 3'b000}) begin
      failures++;
      $display("FAIL reset cnt=%0d div=%0d tick=%b sq=%b ack=%b want 0 2 0 0 0", cnt_o, div_o, tick_o, sq_o, ld_ack_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_div2();
    for (int k = 1; k <= 6; k++) begin
      logic [7:0] c;
      logic b;
      c = 8'(k % 2);
      b = c[0];
      step();
      checks++;
      if ({cnt_o, sq_o, tick_o, div_o} !== {c, b, b, 8'd2}) begin
        failures++;
        $display("FAIL div2[%0d] cnt=%0d sq=%b tick=%b div=%0d want %0d %b %b 2", k, cnt_o, sq_o, tick_o, div_o, c, b, b);
      end
    end
  endtask

  task automatic test_load5();
    ld_i = 1'b1; div_i = 8'd5;
    step();
    ld_i = 1'b0;
    checks++;
    if ({cnt_o, div_o, ld_ack_o} !== {8'd1, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL load5_staged cnt=%0d div=%0d ack=%b want 1 2 0", cnt_o, div_o, ld_ack_o);
    end
    step();
    checks++;
    if ({cnt_o, div_o, ld_ack_o, tick_o, sq_o} !== {8'd0, 8'd5, 3'b100}) begin
      failures++;
      $display("FAIL load5_apply cnt=%0d div=%0d ack=%b tick=%b sq=%b want 0 5 1 0 0", cnt_o, div_o, ld_ack_o, tick_o, sq_o);
    end
    for (int k = 1; k <= 10; k++) begin
      logic [7:0] c;
      c = 8'(k % 5);
      step();
      checks++;
      if ({cnt_o, sq_o, tick_o, ld_ack_o} !== {c, c >= 8'd3, c == 8'd4, 1'b0}) begin
        failures++;
        $display("FAIL div5[%0d] cnt=%0d sq=%b tick=%b ack=%b want %0d %b %b 0", k, cnt_o, sq_o, tick_o, ld_ack_o, c, c >= 8'd3, c == 8'd4);
      end
    end
  endtask

  task automatic test_overwrite();
    int acks;
    phase_clr_i = 1'b1;
    step();
    phase_clr_i = 1'b0;
    checks++;
    if ({cnt_o, div_o, ld_ack_o, sq_o} !== {8'd0, 8'd5, 2'b00}) begin
      failures++;
      $display("FAIL phase_clr cnt=%0d div=%0d ack=%b sq=%b want 0 5 0 0", cnt_o, div_o, ld_ack_o, sq_o);
    end
    ld_i = 1'b1; div_i = 8'd6;
    step();
    div_i = 8'd3;
    step();
    ld_i = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      acks += int'(ld_ack_o);
      checks++;
      if (div_o === 8'd6) begin
        failures++;
        $display("FAIL overwrite_no6[%0d] div=%0d want not 6", k, div_o);
      end
    end
    checks++;
    if ({acks == 1, div_o, cnt_o, tick_o, sq_o} !== {1'b1, 8'd3, 8'd2, 2'b11}) begin
      failures++;
      $display("FAIL overwrite acks=%0d div=%0d cnt=%0d tick=%b sq=%b want 1 3 2 1 1", acks, div_o, cnt_o, tick_o, sq_o);
    end
    for (int k = 1; k <= 3; k++) begin
      logic [7:0] c;
      c = 8'((2 + k) % 3);
      step();
      checks++;
      if ({cnt_o, sq_o, tick_o} !== {c, c >= 8'd2, c == 8'd2}) begin
        failures++;
        $display("FAIL div3[%0d] cnt=%0d sq=%b tick=%b want %0d %b %b", k, cnt_o, sq_o, tick_o, c, c >= 8'd2, c == 8'd2);
      end
    end
  endtask

  task automatic test_enable_hold();
    ld_i = 1'b1; div_i = 8'd8; phase_clr_i = 1'b1;
    step();
    ld_i = 1'b0; phase_clr_i = 1'b0;
    checks++;
    if ({cnt_o, div_o, ld_ack_o, sq_o, tick_o} !== {8'd0, 8'd8, 3'b100}) begin
      failures++;
      $display("FAIL clr_load8 cnt=%0d div=%0d ack=%b sq=%b tick=%b want 0 8 1 0 0", cnt_o, div_o, ld_ack_o, sq_o, tick_o);
    end
    repeat (5) step();
    checks++;
    if ({cnt_o, sq_o, tick_o} !== {8'd5, 2'b10}) begin
      failures++;
      $display("FAIL div8_at5 cnt=%0d sq=%b tick=%b want 5 1 0", cnt_o, sq_o, tick_o);
    end
    en_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({cnt_o, sq_o, tick_o, ld_ack_o} !== {8'd5, 3'b100}) begin
        failures++;
        $display("FAIL en_hold[%0d] cnt=%0d sq=%b tick=%b ack=%b want 5 1 0 0", k, cnt_o, sq_o, tick_o, ld_ack_o);
      end
    end
    en_i = 1'b1;
    step();
    checks++;
    if ({cnt_o, sq_o, tick_o} !== {8'd6, 2'b10}) begin
      failures++;
      $display("FAIL resume6 cnt=%0d sq=%b tick=%b want 6 1 0", cnt_o, sq_o, tick_o);
    end
    step();
    checks++;
    if ({cnt_o, sq_o, tick_o} !== {8'd7, 2'b11}) begin
      failures++;
      $display("FAIL resume7 cnt=%0d sq=%b tick=%b want 7 1 1", cnt_o, sq_o, tick_o);
    end
    step();
    checks++;
    if ({cnt_o, sq_o, tick_o} !== {8'd0, 2'b00}) begin
      failures++;
      $display("FAIL resume_wrap cnt=%0d sq=%b tick=%b want 0 0 0", cnt_o, sq_o, tick_o);
    end
  endtask

  task automatic test_zero();
    ld_i = 1'b1; div_i = 8'd0;
    step();
    ld_i = 1'b0;
    repeat (6) step();
    checks++;
    if ({cnt_o, div_o, ld_ack_o} !== {8'd7, 8'd8, 1'b0}) begin
      failures++;
      $display("FAIL zero_wait cnt=%0d div=%0d ack=%b want 7 8 0", cnt_o, div_o, ld_ack_o);
    end
    step();
    checks++;
    if ({cnt_o, div_o, ld_ack_o, tick_o, sq_o} !== {8'd0, 8'd0, 3'b100}) begin
      failures++;
      $display("FAIL zero_apply cnt=%0d div=%0d ack=%b tick=%b sq=%b want 0 0 1 0 0", cnt_o, div_o, ld_ack_o, tick_o, sq_o);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({cnt_o, tick_o, sq_o, ld_ack_o} !== {8'd0, 3'b000}) begin
        failures++;
        $display("FAIL halted[%0d] cnt=%0d tick=%b sq=%b ack=%b want 0 0 0 0", k, cnt_o, tick_o, sq_o, ld_ack_o);
      end
    end
    en_i = 1'b0; ld_i = 1'b1; div_i = 8'd4;
    step();
    ld_i = 1'b0; en_i = 1'b1;
    checks++;
    if ({div_o, ld_ack_o, cnt_o} !== {8'd4, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL unhalt div=%0d ack=%b cnt=%0d want 4 1 0", div_o, ld_ack_o, cnt_o);
    end
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] c;
      c = 8'(k % 4);
      step();
      checks++;
      if ({cnt_o, sq_o, tick_o} !== {c, c >= 8'd2, c == 8'd3}) begin
        failures++;
        $display("FAIL div4[%0d] cnt=%0d sq=%b tick=%b want %0d %b %b", k, cnt_o, sq_o, tick_o, c, c >= 8'd2, c == 8'd3);
      end
    end
  endtask

  task automatic test_div1();
    phase_clr_i = 1'b1; ld_i = 1'b1; div_i = 8'd1;
    step();
    phase_clr_i = 1'b0; ld_i = 1'b0;
    checks++;
    if ({div_o, ld_ack_o, cnt_o, tick_o} !== {8'd1, 1'b1, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL load1 div=%0d ack=%b cnt=%0d tick=%b want 1 1 0 0", div_o, ld_ack_o, cnt_o, tick_o);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({cnt_o, tick_o, sq_o} !== {8'd0, 2'b10}) begin
        failures++;
        $display("FAIL div1[%0d] cnt=%0d tick=%b sq=%b want 0 1 0", k, cnt_o, tick_o, sq_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    en_i = 1'b0; ld_i = 1'b1; div_i = 8'd7;
    step();
    ld_i = 1'b0;
    checks++;
    if ({div_o, ld_ack_o} !== {8'd1, 1'b0}) begin
      failures++;
      $display("FAIL pend7 div=%0d ack=%b want 1 0", div_o, ld_ack_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt_o, div_o, tick_o, sq_o, ld_ack_o} !== {8'd0, 8'd2, 3'b000}) begin
      failures++;
      $display("FAIL async_reset cnt=%0d div=%0d tick=%b sq=%b ack=%b want 0 2 0 0 0", cnt_o, div_o, tick_o, sq_o, ld_ack_o);
    end
    step();
    rst_n = 1'b1; en_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({div_o, ld_ack_o} !== {8'd2, 1'b0}) begin
        failures++;
        $display("FAIL pend_discard[%0d] div=%0d ack=%b want 2 0", k, div_o, ld_ack_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    step();
    checks++;
    if (cnt_o !== 8'd1) begin
      failures++;
      $display("FAIL b2b_pre cnt=%0d want 1", cnt_o);
    end
    ld_i = 1'b1; div_i = 8'd3;
    step();
    ld_i = 1'b0;
    checks++;
    if ({cnt_o, div_o, ld_ack_o} !== {8'd0, 8'd3, 1'b1}) begin
      failures++;
      $display("FAIL b2b_bypass cnt=%0d div=%0d ack=%b want 0 3 1", cnt_o, div_o, ld_ack_o);
    end
    step();
    checks++;
    if ({cnt_o, ld_ack_o} !== {8'd1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_post cnt=%0d ack=%b want 1 0", cnt_o, ld_ack_o);
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_load5();
    test_overwrite();
    test_enable_hold();
    test_zero();
    test_div1();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
